serial_frame_receiver: RTL and testbench

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

---
 rtl/serial_frame_receiver.sv | 129 ++++++++++++
 tb/tb_serial_frame_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Strobe-sampled serial receiver. A frame is one start bit (0), eight data
//   bits sent MSB first, an optional even-parity bit, and a stop bit (1).
//   Sin is looked at only on rising edges of clk where En=1. Every other
//   cycle leaves the state and the held results alone.
//
// Ports
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high
//   Sin     in   serial line, idles high
//   En      in   bit strobe
//   Dout    out  [7:0] last received byte
//   Dvalid  out  one-cycle pulse after the stop-bit sample
//   PErr    out  parity error for the frame flagged by Dvalid
//   FErr    out  framing error (stop bit sampled 0) for that frame
//   Busy    out  frame in progress (state other than IDLE)
//
// Parameter
//   PARITY_EN  1: an even-parity bit follows the data; 0: no parity bit
//
// State table
//   state  | meaning
//   IDLE   | waiting for a start bit (0) on a strobe
//   DATA   | shifting in the eight data bits, MSB first
//   PARITY | sampling the parity bit (reached only when PARITY_EN=1)
//   STOP   | sampling the stop bit and publishing the frame result
module serial_frame_receiver #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Sin,
  input  logic       En,
  output logic [7:0] Dout,
  output logic       Dvalid,
  output logic       PErr,
  output logic       FErr,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (En) begin
      case (state)
        IDLE: begin
          if (!Sin) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state_nxt = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: state_nxt = STOP;
        // The stop sample always returns to IDLE, even when it reads 0.
        // A low stop bit is a framing error, not the start of the next frame.
        STOP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      par_bit   <= 1'b0;
      Dout      <= 8'h00;
      Dvalid    <= 1'b0;
      PErr      <= 1'b0;
      FErr      <= 1'b0;
    end else begin
      // Dvalid drops on every edge unless this edge samples a stop bit.
      // This keeps the pulse to one cycle and forces it low on En=0 cycles.
      Dvalid <= 1'b0;
      if (En) begin
        case (state)
          IDLE: begin
            if (!Sin) begin
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift_reg <= {shift_reg[6:0], Sin};
            // The counter wraps from 7 back to 0 on the eighth data bit.
            bit_cnt   <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_bit <= Sin;
          end
          STOP: begin
            Dout   <= shift_reg;
            Dvalid <= 1'b1;
            FErr   <= ~Sin;
            // Even parity: the data bits and the parity bit together
            // should contain an even number of ones.
            PErr   <= PARITY_EN ? ((^shift_reg) ^ par_bit) : 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Directed bench for serial_frame_receiver. One instance uses parity and
//   one does not. Both share clk, reset, Sin and En. Frame vectors come from
//   a table. The reset, idle-hold and no-parity back-to-back cases are
//   written out by hand.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin;
  logic       en;

  logic [7:0] dout1, dout0;
  logic       dvalid1, dvalid0;
  logic       perr1, perr0;
  logic       ferr1, ferr0;
  logic       busy1, busy0;

  serial_frame_receiver #(.PARITY_EN(1'b1)) dut_par (
    .clk(clk), .reset(reset), .Sin(sin), .En(en),
    .Dout(dout1), .Dvalid(dvalid1), .PErr(perr1), .FErr(ferr1), .Busy(busy1)
  );

  serial_frame_receiver #(.PARITY_EN(1'b0)) dut_nopar (
    .clk(clk), .reset(reset), .Sin(sin), .En(en),
    .Dout(dout0), .Dvalid(dvalid0), .PErr(perr0), .FErr(ferr0), .Busy(busy0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses1 = 0;
  int busy1_cyc = 0;
  int last_pulse0 = -1;
  int prev_pulse0 = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dvalid1) pulses1 = pulses1 + 1;
    if (busy1) busy1_cyc = busy1_cyc + 1;
    if (dvalid0) begin
      prev_pulse0 = last_pulse0;
      last_pulse0 = cyc;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One strobe of bit s, followed by gap cycles with En=0.
  // During those cycles the parity instance must stay mid-frame and quiet.
  task automatic strobe(input logic s, input int gap);
    sin = s;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    sin = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      chk("gap_dvalid", 32'(dvalid1), 32'd0);
      chk("gap_busy", 32'(busy1), 32'd1);
    end
  endtask

  // Returns 1 ns after the stop-bit edge, which is the Dvalid cycle.
  task automatic send(input logic [7:0] b, input logic with_par, input logic par,
                      input logic stp, input int gap);
    strobe(1'b0, gap);
    for (int i = 7; i >= 0; i--) strobe(b[i], gap);
    if (with_par) strobe(par, gap);
    strobe(stp, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p;
    int bc;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 3, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 0, 8'h80, 1'b1, 1'b1};

    reset = 1'b1;
    sin   = 1'b1;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout1), 32'h00);
    chk("rst_dvalid", 32'(dvalid1), 32'd0);
    chk("rst_perr", 32'(perr1), 32'd0);
    chk("rst_ferr", 32'(ferr1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    reset = 1'b0;

    repeat (3) strobe(1'b1, 0);
    chk("idle_busy", 32'(busy1), 32'd0);

    // The frames in the table run back to back: each start bit is the next
    // strobe after the previous stop bit, with one En=0 cycle between them.
    for (int i = 0; i < 6; i++) begin
      p  = pulses1;
      bc = busy1_cyc;
      send(vecs[i].data, 1'b1, vecs[i].par, vecs[i].stp, vecs[i].gap);
      chk("vec_dout", 32'(dout1), 32'(vecs[i].exp_dout));
      chk("vec_dvalid", 32'(dvalid1), 32'd1);
      chk("vec_perr", 32'(perr1), 32'(vecs[i].exp_perr));
      chk("vec_ferr", 32'(ferr1), 32'(vecs[i].exp_ferr));
      @(posedge clk);
      #1;
      chk("vec_dvalid_drop", 32'(dvalid1), 32'd0);
      chk("vec_dout_hold", 32'(dout1), 32'(vecs[i].exp_dout));
      chk("vec_pulse_count", 32'(pulses1 - p), 32'd1);
      chk("vec_busy_cycles", 32'(busy1_cyc - bc), 32'(10 * (vecs[i].gap + 1)));
      chk("vec_busy_end", 32'(busy1), 32'd0);
    end

    // Reset after four data bits, while En=1 and Sin=0.
    p = pulses1;
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    reset = 1'b1;
    en    = 1'b1;
    sin   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b0;
    sin   = 1'b1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_dout", 32'(dout1), 32'h00);
    chk("midrst_perr", 32'(perr1), 32'd0);
    chk("midrst_ferr", 32'(ferr1), 32'd0);
    repeat (20) strobe(1'b1, 0);
    chk("midrst_no_pulse", 32'(pulses1 - p), 32'd0);
    chk("midrst_busy_after", 32'(busy1), 32'd0);
    chk("midrst_dout_after", 32'(dout1), 32'h00);
    send(8'h5A, 1'b1, 1'b0, 1'b1, 0);
    chk("postrst_dout", 32'(dout1), 32'h5A);
    chk("postrst_dvalid", 32'(dvalid1), 32'd1);
    chk("postrst_perr", 32'(perr1), 32'd0);
    @(posedge clk);
    #1;

    // Without parity: two frames with no strobe between them.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h81, 1'b0, 1'b0, 1'b1, 0);
    chk("np1_dout", 32'(dout0), 32'h81);
    chk("np1_dvalid", 32'(dvalid0), 32'd1);
    chk("np1_perr", 32'(perr0), 32'd0);
    chk("np1_ferr", 32'(ferr0), 32'd0);
    send(8'h7E, 1'b0, 1'b0, 1'b1, 0);
    chk("np2_dout", 32'(dout0), 32'h7E);
    chk("np2_dvalid", 32'(dvalid0), 32'd1);
    chk("np2_perr", 32'(perr0), 32'd0);
    chk("np2_ferr", 32'(ferr0), 32'd0);
    @(posedge clk);
    #1;
    chk("np_dvalid_drop", 32'(dvalid0), 32'd0);
    chk("np_pulse_spacing", 32'(last_pulse0 - prev_pulse0), 32'd10);
    chk("np_busy_end", 32'(busy0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
